// File: rtl/regs_arbiter_if.sv
// One requester's request/response channel into regs_arbiter.
// The requester drives the master side and the arbiter drives the slave side.
interface regs_arbiter_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 req;
    logic                 we;
    logic [BUS_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0] wdata;
    logic                 ack;
    logic [BUS_WIDTH-1:0] rdata;
    logic                 err;

    modport master (output req, we, addr, wdata, input  ack, rdata, err);
    modport slave  (input  req, we, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/regs_arbiter.sv
// Round-robin arbiter and sequencer that shares the regs register file's single
// write port and single read port between requester A (core) and B (debug/host).
module regs_arbiter #(
    parameter int BUS_WIDTH = 32,
    parameter int REGS_NUM  = 16,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    regs_arbiter_if.slave        a,
    regs_arbiter_if.slave        b,
    output logic [BUS_WIDTH-1:0] addr_write,
    output logic [BUS_WIDTH-1:0] data_write,
    output logic [BUS_WIDTH-1:0] addr_read,
    input  logic [BUS_WIDTH-1:0] data_read,
    input  logic                 ready
);
    localparam int                   CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [BUS_WIDTH-1:0] PARK_ADDR = BUS_WIDTH'(REGS_NUM);
    localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t               state;
    state_t               next_state;

    // Requester ids: 0 = A, 1 = B.
    logic                 rr;
    logic                 gnt;
    logic [BUS_WIDTH-1:0] lat_addr;
    logic [BUS_WIDTH-1:0] lat_wdata;
    logic [CNT_W-1:0]     cnt;

    logic                 any_req;
    logic                 pick_b;
    logic                 pick_we;
    logic                 pick_ok;
    logic [BUS_WIDTH-1:0] pick_addr;
    logic [BUS_WIDTH-1:0] pick_wdata;
    logic                 timed_out;

    logic                 done;
    logic                 done_b;
    logic                 done_err;
    logic [BUS_WIDTH-1:0] done_data;

    // rr only breaks ties; a lone request always wins.
    always_comb begin
        any_req    = a.req | b.req;
        pick_b     = (a.req && b.req) ? rr : b.req;
        pick_we    = pick_b ? b.we    : a.we;
        pick_addr  = pick_b ? b.addr  : a.addr;
        pick_wdata = pick_b ? b.wdata : a.wdata;
        pick_ok    = pick_addr < PARK_ADDR;
        timed_out  = cnt == CNT_LIMIT;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (any_req) begin
                    if (!pick_ok) begin
                        next_state = RESP;
                    end else if (pick_we) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            WRITE:   next_state = RESP;
            READ:    if (ready || timed_out) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The write address is decoded from state so reset parks it without waiting for a clock.
    always_comb begin
        addr_write = (state == WRITE) ? lat_addr  : PARK_ADDR;
        data_write = (state == WRITE) ? lat_wdata : '0;
        done       = next_state == RESP;
        done_b     = (state == IDLE) ? pick_b : gnt;
        done_err   = 1'b0;
        done_data  = '0;
        if (state == IDLE) begin
            done_err = 1'b1;
        end else if (state == READ) begin
            done_err  = !ready;
            done_data = ready ? data_read : '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rr        <= 1'b0;
            gnt       <= 1'b0;
            lat_addr  <= PARK_ADDR;
            lat_wdata <= '0;
            cnt       <= '0;
            addr_read <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= pick_b;
                        lat_addr  <= pick_addr;
                        lat_wdata <= pick_wdata;
                        if (pick_ok && !pick_we) begin
                            addr_read <= pick_addr;
                        end
                    end
                end
                READ: begin
                    if (!ready && !timed_out) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    cnt <= '0;
                    rr  <= ~gnt;
                end
                default: begin
                end
            endcase
        end
    end

    // Response is registered on entry to RESP, so ack lines up with the RESP cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            a.ack   <= 1'b0;
            a.err   <= 1'b0;
            a.rdata <= '0;
            b.ack   <= 1'b0;
            b.err   <= 1'b0;
            b.rdata <= '0;
        end else begin
            a.ack <= done && !done_b;
            a.err <= done && !done_b && done_err;
            b.ack <= done && done_b;
            b.err <= done && done_b && done_err;
            if (done && !done_b) begin
                a.rdata <= done_data;
            end
            if (done && done_b) begin
                b.rdata <= done_data;
            end
        end
    end
endmodule

// File: tb/tb_regs_arbiter.sv
// Self-checking bench for regs_arbiter: directed vector table, multi-cycle
// corner sequences and random transactions against a transaction-level model.
module tb_regs_arbiter;
    localparam int BW = 32;
    localparam int RN = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          nreset;
    logic [BW-1:0] addr_write;
    logic [BW-1:0] data_write;
    logic [BW-1:0] addr_read;
    logic [BW-1:0] data_read;
    logic          ready;

    regs_arbiter_if #(.BUS_WIDTH(BW)) a_if ();
    regs_arbiter_if #(.BUS_WIDTH(BW)) b_if ();

    regs_arbiter #(.BUS_WIDTH(BW), .REGS_NUM(RN), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .a          (a_if),
        .b          (b_if),
        .addr_write (addr_write),
        .data_write (data_write),
        .addr_read  (addr_read),
        .data_read  (data_read),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Register file stand-in: writes on every edge with an in-range address.
    logic [BW-1:0] regmem [RN] = '{default: '0};
    int            wr_cycles = 0;

    assign data_read = (addr_read < BW'(RN)) ? regmem[addr_read[3:0]] : '0;

    always @(posedge clk) begin
        if (addr_write < BW'(RN)) begin
            regmem[addr_write[3:0]] <= data_write;
            wr_cycles <= wr_cycles + 1;
        end
    end

    int acks_a    = 0;
    int acks_b    = 0;
    int both_acks = 0;

    always @(negedge clk) begin
        if (a_if.ack) acks_a++;
        if (b_if.ack) acks_b++;
        if (a_if.ack && b_if.ack) both_acks++;
    end

    // Expected state of the world, updated one completed transaction at a time.
    logic [BW-1:0] model_mem [RN];
    int            exp_writes = 0;
    int            exp_acks_a = 0;
    int            exp_acks_b = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          who_b;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          wait_cyc;
        bit          scramble;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Transaction-level rules: bad address errors in 2 cycles, writes take 3,
    // reads take 3 plus the ready wait unless the wait exceeds TIMEOUT.
    task automatic modelTxn(input bit who_b, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int wait_cyc,
                            output int exp_lat, output bit exp_err, output logic [31:0] exp_rd);
        exp_rd = '0;
        if (addr >= 32'(RN)) begin
            exp_err = 1'b1;
            exp_lat = 2;
        end else if (we) begin
            exp_err = 1'b0;
            exp_lat = 3;
            model_mem[addr[3:0]] = wdata;
            exp_writes++;
        end else if (wait_cyc <= TO) begin
            exp_err = 1'b0;
            exp_lat = 3 + wait_cyc;
            exp_rd  = model_mem[addr[3:0]];
        end else begin
            exp_err = 1'b1;
            exp_lat = 3 + TO;
        end
        if (who_b) exp_acks_b++;
        else       exp_acks_a++;
    endtask

    // Issues one request from IDLE, holds ready low for wait_cyc read cycles,
    // waits for the ack and leaves the DUT back in IDLE.
    task automatic applyStimulus(input bit who_b, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int wait_cyc, input bit scramble,
                                 output int lat, output logic [31:0] rdata, output bit err);
        int cyc;
        bit seen;
        cyc   = 0;
        seen  = 1'b0;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        ready = 1'b0;
        if (who_b) begin
            b_if.we = we; b_if.addr = addr; b_if.wdata = wdata; b_if.req = 1'b1;
        end else begin
            a_if.we = we; a_if.addr = addr; a_if.wdata = wdata; a_if.req = 1'b1;
        end
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            ready = (cyc > wait_cyc);
            if (scramble && cyc == 1) begin
                if (who_b) begin
                    b_if.we = ~we; b_if.addr = $urandom; b_if.wdata = $urandom;
                end else begin
                    a_if.we = ~we; a_if.addr = $urandom; a_if.wdata = $urandom;
                end
            end
            if (who_b ? b_if.ack : a_if.ack) begin
                seen  = 1'b1;
                lat   = cyc + 1;
                rdata = who_b ? b_if.rdata : a_if.rdata;
                err   = who_b ? b_if.err : a_if.err;
            end
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        ready    = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL ack wait: no ack after %0d cycles, expected one", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic runTxn(input string tag, input bit who_b, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int wait_cyc, input bit scramble);
        int          lat, exp_lat;
        bit          er, exp_er;
        logic [31:0] rd, exp_rd;
        modelTxn(who_b, we, addr, wdata, wait_cyc, exp_lat, exp_er, exp_rd);
        applyStimulus(who_b, we, addr, wdata, wait_cyc, scramble, lat, rd, er);
        checkOutput($sformatf("%s latency", tag), lat, exp_lat);
        checkOutput($sformatf("%s err", tag), 32'(er), 32'(exp_er));
        if (!we) checkOutput($sformatf("%s rdata", tag), rd, exp_rd);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n, guard, lat, m_lat;
        bit          er, m_err;
        logic [31:0] rd, m_rd, a_val;

        for (int i = 0; i < RN; i++) model_mem[i] = '0;

        vecs[0]  = '{0, 1, 32'd1,          32'd2,          0,  0, 3,  0, 32'd0};
        vecs[1]  = '{0, 0, 32'd1,          32'd0,          0,  0, 3,  0, 32'd2};
        vecs[2]  = '{1, 0, 32'd16,         32'd0,          0,  0, 2,  1, 32'd0};
        vecs[3]  = '{0, 0, 32'd3,          32'd0,          20, 0, 11, 1, 32'd0};
        vecs[4]  = '{0, 0, 32'd1,          32'd0,          0,  0, 3,  0, 32'd2};
        vecs[5]  = '{1, 1, 32'hFFFF_FFF0,  32'h55,         0,  0, 2,  1, 32'd0};
        vecs[6]  = '{1, 1, 32'd15,         32'hDEAD_BEEF,  0,  0, 3,  0, 32'd0};
        vecs[7]  = '{1, 0, 32'd15,         32'd0,          3,  0, 6,  0, 32'hDEAD_BEEF};
        vecs[8]  = '{0, 0, 32'd15,         32'd0,          8,  0, 11, 0, 32'hDEAD_BEEF};
        vecs[9]  = '{0, 0, 32'd15,         32'd0,          9,  0, 11, 1, 32'd0};
        vecs[10] = '{0, 1, 32'd0,          32'hA5A5_A5A5,  0,  1, 3,  0, 32'd0};
        vecs[11] = '{1, 0, 32'd0,          32'd0,          1,  0, 4,  0, 32'hA5A5_A5A5};
        vecs[12] = '{0, 0, 32'h8000_0000,  32'd0,          0,  0, 2,  1, 32'd0};
        vecs[13] = '{1, 0, 32'd4,          32'd0,          0,  0, 3,  0, 32'd0};

        nreset = 1'b0;
        ready  = 1'b0;
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.wdata = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset a_ack", 32'(a_if.ack), 0);
        checkOutput("reset b_ack", 32'(b_if.ack), 0);
        checkOutput("reset a_err", 32'(a_if.err), 0);
        checkOutput("reset b_err", 32'(b_if.err), 0);
        checkOutput("reset a_rdata", a_if.rdata, 0);
        checkOutput("reset b_rdata", b_if.rdata, 0);
        checkOutput("reset addr_write", addr_write, 32'd16);
        checkOutput("reset data_write", data_write, 0);
        checkOutput("reset addr_read", addr_read, 0);
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Abort a stalled read with reset; the next read must start from IDLE.
        a_if.we = 1'b0; a_if.addr = 32'd3; a_if.req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid-read addr_read", addr_read, 32'd3);
        nreset = 1'b0;
        #1;
        checkOutput("mid-read reset a_ack", 32'(a_if.ack), 0);
        checkOutput("mid-read reset b_ack", 32'(b_if.ack), 0);
        checkOutput("mid-read reset addr_write", addr_write, 32'd16);
        checkOutput("mid-read reset addr_read", addr_read, 0);
        a_if.req = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;
        runTxn("post-reset read r0", 0, 0, 32'd0, 32'd0, 0, 0);

        // Reset during the WRITE cycle must pull the write port back to park at once.
        a_if.we = 1'b1; a_if.addr = 32'd6; a_if.wdata = 32'h77; a_if.req = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("write cycle addr_write", addr_write, 32'd6);
        checkOutput("write cycle data_write", data_write, 32'h77);
        nreset = 1'b0;
        #1;
        checkOutput("mid-write reset addr_write", addr_write, 32'd16);
        a_if.req = 1'b0;
        @(posedge clk);
        #1;
        nreset = 1'b1;
        @(posedge clk);
        #1;

        // Both requesters hold req high: grants must alternate A, B, A, B.
        a_val = 32'd1;
        a_if.we = 1'b1; a_if.addr = 32'd15; a_if.wdata = a_val;
        b_if.we = 1'b0; b_if.addr = 32'd15;
        ready = 1'b1;
        a_if.req = 1'b1; b_if.req = 1'b1;
        n = 0;
        guard = 0;
        while (n < 8 && guard < 80) begin
            @(posedge clk);
            #1;
            guard++;
            if (a_if.ack || b_if.ack) begin
                checkOutput($sformatf("contention grant %0d is B", n), 32'(b_if.ack), 32'(n % 2));
                if (b_if.ack) begin
                    checkOutput($sformatf("contention B rdata %0d", n), b_if.rdata, model_mem[15]);
                    checkOutput($sformatf("contention B err %0d", n), 32'(b_if.err), 0);
                    exp_acks_b++;
                end else begin
                    checkOutput($sformatf("contention A err %0d", n), 32'(a_if.err), 0);
                    model_mem[15] = a_val;
                    exp_writes++;
                    exp_acks_a++;
                    a_val = a_val + 32'd1;
                    a_if.wdata = a_val;
                end
                n++;
            end
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        ready = 1'b0;
        checkOutput("contention transactions", 32'(n), 32'd8);
        @(posedge clk);
        #1;

        // A rejected address must leave the read port where the last good read put it.
        runTxn("read r5", 0, 0, 32'd5, 32'd0, 0, 0);
        runTxn("B read oor 20", 1, 0, 32'd20, 32'd0, 0, 0);
        checkOutput("oor keeps addr_read", addr_read, 32'd5);

        for (int i = 0; i < NVEC; i++) begin
            modelTxn(vecs[i].who_b, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wait_cyc,
                     m_lat, m_err, m_rd);
            applyStimulus(vecs[i].who_b, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                          vecs[i].wait_cyc, vecs[i].scramble, lat, rd, er);
            checkOutput($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
            if (!vecs[i].we) checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
        end

        for (int i = 0; i < 150; i++) begin
            bit          r_b, r_we, r_scr;
            logic [31:0] r_addr;
            r_b   = 1'($urandom_range(0, 1));
            r_we  = 1'($urandom_range(0, 1));
            r_scr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) r_addr = 32'($urandom) | 32'h10;
            else                           r_addr = 32'($urandom_range(0, RN - 1));
            runTxn($sformatf("rand%0d", i), r_b, r_we, r_addr, 32'($urandom),
                   int'($urandom_range(0, TO + 2)), r_scr);
        end

        for (int i = 0; i < RN; i++) begin
            checkOutput($sformatf("regfile r%0d", i), regmem[i], model_mem[i]);
        end
        checkOutput("write cycles", 32'(wr_cycles), 32'(exp_writes));
        checkOutput("a_ack count", 32'(acks_a), 32'(exp_acks_a));
        checkOutput("b_ack count", 32'(acks_b), 32'(exp_acks_b));
        checkOutput("simultaneous acks", 32'(both_acks), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regs_arbiter.md
Name: regs_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the `regs` register file.
- Shares the regfile's single write port (addr_write/data_write) and single read port (addr_read/data_read/ready) between requester A (core) and requester B (debug/host).
- Uses round-robin arbitration and a per-transaction valid/ack handshake.
- Handles range checking and a read timeout, so requesters never drive the regfile directly.

Parameters:
- BUS_WIDTH, 32, width of address and data buses (matches regs BUS_WIDTH).
- REGS_NUM, 16, number of registers; valid addresses are 0..REGS_NUM-1.
- TIMEOUT, 8, max cycles to wait for regs `ready` on a read before an error response.

Ports:
- clk  in  1  system clock, all state on rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- a_req, b_req  in  1  request valid, held until ack.
- a_we, b_we  in  1  1 = write, 0 = read.
- a_addr, b_addr  in  BUS_WIDTH  register address.
- a_wdata, b_wdata  in  BUS_WIDTH  write data.
- a_ack, b_ack  out  1  one-cycle completion pulse.
- a_rdata, b_rdata  out  BUS_WIDTH  read data, valid with ack.
- a_err, b_err  out  1  valid with ack: out-of-range address or read timeout.
- addr_write  out  BUS_WIDTH  to regs.
- data_write  out  BUS_WIDTH  to regs.
- addr_read  out  BUS_WIDTH  to regs.
- data_read  in  BUS_WIDTH  from regs.
- ready  in  1  from regs, read data valid for addr_read.

Behaviour:
- Reset (async, nreset=0):
  - FSM enters IDLE; rr pointer = A.
  - All ack/err = 0; rdata = 0.
  - addr_write = REGS_NUM (park address; the regfile ignores out-of-range writes); data_write = 0; addr_read = 0.
  - Timeout counter = 0.
- Regfile contract: the regfile writes data_write into addr_write on every rising edge with addr_write < REGS_NUM, so addr_write is held at REGS_NUM whenever no write is in progress.
- FSM states:
  - IDLE: if any req, grant and latch we/addr/wdata and requester id. Out-of-range addr (>= REGS_NUM) goes to RESP with err=1 and no regfile access. Otherwise, write goes to WRITE and read goes to READ.
  - WRITE (1 cycle): drive addr_write/data_write, then go to RESP. Next cycle addr_write returns to REGS_NUM.
  - READ: drive addr_read and increment the timeout counter each cycle.
    - If ready=1: capture data_read, go to RESP with err=0.
    - If the counter reaches TIMEOUT with no ready: go to RESP with err=1 and rdata=0.
  - RESP (1 cycle): pulse ack of the granted requester with its rdata/err; the other requester sees ack=0. Clear the counter; toggle rr to the other requester; go to IDLE.
- Arbitration:
  - Simultaneous a_req and b_req in IDLE: grant the requester at rr.
  - Single req: grant it regardless of rr; rr still flips to the non-granted side after completion.
- Latency:
  - Write: 3 cycles from req sampled in IDLE to ack (IDLE → WRITE → RESP).
  - Read: 3 + (cycles waiting for ready) cycles.
  - Error on bad address: 2 cycles.
- Requesters must hold req and payload until ack. Payload is latched at grant, so changes after grant are ignored.
- A req that is still high on the cycle after ack is a new transaction.
- Back-to-back transactions: minimum one IDLE cycle between transactions.
- Starvation-free: with both requesters continuously requesting, grants strictly alternate A, B, A, B.
- Reset mid-transaction: the transaction is aborted with no ack. addr_write returns immediately (async) to REGS_NUM, so no partial write occurs after reset assertion.
- Address compare is unsigned over the full BUS_WIDTH.
- ack, rdata and err are registered outputs. rdata holds its last value between acks; err clears when ack deasserts.

Test Plan:
- Reset: nreset=0 mid-READ → a_ack=b_ack=0, addr_write=16, FSM in IDLE. After release, the first a_req read of reg 0 returns 0 with ack 3 cycles later.
- Single write/read: A writes addr 1 data 2 → a_ack after 3 cycles, err=0. A reads addr 1 → a_rdata=2, a_err=0.
- Contention: A and B both request continuously, A writes reg 15=1 and B reads reg 15.
  - Grant order is A then B; B's rdata=1.
  - Over 8 transactions, acks alternate A, B, A, B.
  - b_ack is never asserted in the same cycle as a_ack.
- Out of range: B reads addr 16 → b_ack 2 cycles later, b_err=1, b_rdata=0; addr_read unchanged, no write.
- Timeout: model holds ready=0; A reads addr 3 → a_ack after 3+TIMEOUT cycles (11) with a_err=1. The next read with ready=1 succeeds.
- Park check: across all scenarios, addr_write=16 on every cycle not in WRITE. A scoreboard of regfile contents matches expected values.
